// File: rtl/pmem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the combinational program memory and
// fills the IF/ID register, with stall hold, branch redirect/flush, HALT detection and drain.
module pmem_fetch_ctrl #(
  parameter int                 ADDR_W       = 4,
  parameter int                 INSTR_W      = 10,
  parameter logic [3:0]         HALT_OPCODE  = 4'b1111,
  parameter logic [INSTR_W-1:0] NOP_INSTR    = '0,
  parameter int                 DRAIN_CYCLES = 3,
  parameter bit                 WRAP_EN      = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [ADDR_W-1:0]  pmem_addr,
  input  logic [INSTR_W-1:0] pmem_instr,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic               ifid_valid,
  output logic               busy,
  output logic               halted,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int                CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  drain_cnt;
  logic              fetch_halt;
  logic              fetch_end;

  assign pmem_addr  = pc;
  assign fetch_halt = (pmem_instr[INSTR_W-1 -: 4] == HALT_OPCODE);
  // Without wrap, fetching the last address ends the program exactly like a HALT word.
  assign fetch_end  = (WRAP_EN == 1'b0) && (pc == LAST_ADDR);

  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign halted    = (state == S_HALT);
  assign state_dbg = state;

  // ifid_valid qualifies ifid_instr/ifid_pc: decode may consume IF/ID only on cycles where it is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state <= S_RUN;
            pc    <= '0;
          end
        end

        S_RUN: begin
          if (br_taken) begin
            pc         <= br_target;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
          end else if (!stall) begin
            ifid_instr <= pmem_instr;
            ifid_pc    <= pc;
            ifid_valid <= 1'b1;
            if (fetch_halt || fetch_end) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end

        S_DRAIN: begin
          // An older branch still in flight can resolve here and restart fetch.
          if (br_taken) begin
            pc         <= br_target;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
            drain_cnt  <= '0;
            state      <= S_RUN;
          end else if (!stall) begin
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
            if (drain_cnt == DRAIN_LAST) begin
              drain_cnt <= '0;
              state     <= S_HALT;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_fetch_ctrl.sv
// Bench for pmem_fetch_ctrl: directed vector table, hand sequences for multi-cycle corners,
// and randomized runs against a behavioural fetch model for a wrapping and a non-wrapping build.
module tb_pmem_fetch_ctrl;

  localparam logic [9:0] NOP = 10'h000;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_HALT  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       br_taken = 1'b0;
  logic [3:0] br_target = 4'd0;

  logic [9:0] prog [16];
  logic [3:0] pm_addr   [2];
  logic [9:0] pm_instr  [2];
  logic [9:0] ifid_ins  [2];
  logic [3:0] ifid_pcw  [2];
  logic       ifid_val  [2];
  logic       busy_w    [2];
  logic       halted_w  [2];
  logic [1:0] state_w   [2];

  int n_pass  = 0;
  int n_total = 0;

  assign pm_instr[0] = prog[pm_addr[0]];
  assign pm_instr[1] = prog[pm_addr[1]];

  always #5 clk = ~clk;

  pmem_fetch_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .pmem_addr(pm_addr[0]), .pmem_instr(pm_instr[0]),
    .ifid_instr(ifid_ins[0]), .ifid_pc(ifid_pcw[0]), .ifid_valid(ifid_val[0]),
    .busy(busy_w[0]), .halted(halted_w[0]), .state_dbg(state_w[0])
  );

  pmem_fetch_ctrl #(.DRAIN_CYCLES(2), .WRAP_EN(1'b0)) u_dut_nw (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .pmem_addr(pm_addr[1]), .pmem_instr(pm_instr[1]),
    .ifid_instr(ifid_ins[1]), .ifid_pc(ifid_pcw[1]), .ifid_valid(ifid_val[1]),
    .busy(busy_w[1]), .halted(halted_w[1]), .state_dbg(state_w[1])
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic st, input logic sl, input logic br, input logic [3:0] tg);
    start = st; stall = sl; br_taken = br; br_target = tg;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 4'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input int i, input string tag);
    chk($sformatf("%s_addr%0d", tag, i),   pm_addr[i],  0);
    chk($sformatf("%s_valid%0d", tag, i),  ifid_val[i], 0);
    chk($sformatf("%s_instr%0d", tag, i),  ifid_ins[i], NOP);
    chk($sformatf("%s_ifpc%0d", tag, i),   ifid_pcw[i], 0);
    chk($sformatf("%s_busy%0d", tag, i),   busy_w[i],   0);
    chk($sformatf("%s_halted%0d", tag, i), halted_w[i], 0);
  endtask

  // ---------------- behavioural model ----------------
  int         m_mode  [2];
  int         m_pc    [2];
  int         m_ipc   [2];
  int         m_left  [2];
  logic [9:0] m_instr [2];
  bit         m_valid [2];
  bit         m_wrap  [2] = '{1'b1, 1'b0};
  int         m_drain [2] = '{3, 2};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_pc[i] = 0; m_ipc[i] = 0; m_left[i] = 0;
      m_instr[i] = NOP; m_valid[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input bit st, input bit sl, input bit br, input int tg);
    logic [9:0] w;
    w = prog[m_pc[i]];
    case (m_mode[i])
      M_IDLE, M_HALT: begin
        if (st) begin m_mode[i] = M_RUN; m_pc[i] = 0; end
      end
      M_RUN: begin
        if (br) begin
          m_pc[i] = tg; m_valid[i] = 1'b0; m_instr[i] = NOP;
        end else if (!sl) begin
          m_valid[i] = 1'b1; m_instr[i] = w; m_ipc[i] = m_pc[i];
          if (w[9:6] == 4'hF || (!m_wrap[i] && m_pc[i] == 15)) begin
            m_mode[i] = M_DRAIN; m_left[i] = m_drain[i];
          end else begin
            m_pc[i] = (m_pc[i] + 1) % 16;
          end
        end
      end
      default: begin
        if (br) begin
          m_pc[i] = tg; m_valid[i] = 1'b0; m_instr[i] = NOP; m_mode[i] = M_RUN;
        end else if (!sl) begin
          m_valid[i] = 1'b0;
          m_left[i]--;
          if (m_left[i] == 0) begin m_mode[i] = M_HALT; m_instr[i] = NOP; end
        end
      end
    endcase
  endtask

  task automatic model_check(input int i, input int cyc);
    string p;
    p = $sformatf("rnd_d%0d_c%0d", i, cyc);
    chk({p, "_addr"},   pm_addr[i],  m_pc[i]);
    chk({p, "_valid"},  ifid_val[i], int'(m_valid[i]));
    chk({p, "_busy"},   busy_w[i],   int'(m_mode[i] == M_RUN || m_mode[i] == M_DRAIN));
    chk({p, "_halted"}, halted_w[i], int'(m_mode[i] == M_HALT));
    if (m_valid[i]) chk({p, "_ifpc"}, ifid_pcw[i], m_ipc[i]);
    if (!(m_mode[i] == M_DRAIN && !m_valid[i])) chk({p, "_instr"}, ifid_ins[i], m_instr[i]);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       st, sl, br;
    logic [3:0] tg;
    logic [3:0] e_addr;
    logic       e_valid;
    logic [3:0] e_ipc;
    logic [9:0] e_instr;
    logic       e_busy, e_halted, ci;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic st, input logic sl, input logic br, input logic [3:0] tg,
                              input logic [3:0] ad, input logic va, input logic [3:0] ip,
                              input logic [9:0] ins, input logic bu, input logic ha,
                              input logic ci);
    vec_t v;
    v.st = st; v.sl = sl; v.br = br; v.tg = tg;
    v.e_addr = ad; v.e_valid = va; v.e_ipc = ip; v.e_instr = ins;
    v.e_busy = bu; v.e_halted = ha; v.ci = ci;
    return v;
  endfunction

  initial begin
    logic [9:0] w;
    int         wrap_exp [4] = '{14, 15, 0, 1};

    // ---- reset values, asserted from time 0 ----
    for (int k = 0; k < 16; k++) prog[k] = 10'h040 | 10'(k);
    #2;
    check_reset_vals(0, "rst");
    check_reset_vals(1, "rst");
    @(negedge clk);
    rst_n = 1'b1;

    // ---- directed table: HALT word at address 4 ----
    prog[4] = 10'h3C4;
    tbl[0]  = mk(0,0,0,4'd0,  4'd0, 0,4'd0, NOP,    0,0,1);
    tbl[1]  = mk(1,0,0,4'd0,  4'd0, 0,4'd0, NOP,    1,0,1);
    tbl[2]  = mk(0,0,0,4'd0,  4'd1, 1,4'd0, 10'h040,1,0,1);
    tbl[3]  = mk(0,0,0,4'd0,  4'd2, 1,4'd1, 10'h041,1,0,1);
    tbl[4]  = mk(0,0,0,4'd0,  4'd3, 1,4'd2, 10'h042,1,0,1);
    tbl[5]  = mk(0,0,0,4'd0,  4'd4, 1,4'd3, 10'h043,1,0,1);
    tbl[6]  = mk(0,0,0,4'd0,  4'd4, 1,4'd4, 10'h3C4,1,0,1);
    tbl[7]  = mk(0,0,0,4'd0,  4'd4, 0,4'd0, NOP,    1,0,0);
    tbl[8]  = mk(0,0,0,4'd0,  4'd4, 0,4'd0, NOP,    1,0,0);
    tbl[9]  = mk(0,0,0,4'd0,  4'd4, 0,4'd0, NOP,    0,1,1);
    tbl[10] = mk(0,1,1,4'd7,  4'd4, 0,4'd0, NOP,    0,1,1);
    tbl[11] = mk(1,0,0,4'd0,  4'd0, 0,4'd0, NOP,    1,0,1);
    tbl[12] = mk(0,0,0,4'd0,  4'd1, 1,4'd0, 10'h040,1,0,1);
    tbl[13] = mk(0,0,0,4'd0,  4'd2, 1,4'd1, 10'h041,1,0,1);
    tbl[14] = mk(0,0,0,4'd0,  4'd3, 1,4'd2, 10'h042,1,0,1);
    tbl[15] = mk(0,1,0,4'd0,  4'd3, 1,4'd2, 10'h042,1,0,1);
    tbl[16] = mk(0,1,0,4'd0,  4'd3, 1,4'd2, 10'h042,1,0,1);
    tbl[17] = mk(0,0,0,4'd0,  4'd4, 1,4'd3, 10'h043,1,0,1);
    tbl[18] = mk(0,1,1,4'd9,  4'd9, 0,4'd0, NOP,    1,0,1);
    tbl[19] = mk(0,0,0,4'd0,  4'd10,1,4'd9, 10'h049,1,0,1);
    tbl[20] = mk(1,0,0,4'd0,  4'd11,1,4'd10,10'h04A,1,0,1);
    tbl[21] = mk(0,0,0,4'd0,  4'd12,1,4'd11,10'h04B,1,0,1);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].st, tbl[i].sl, tbl[i].br, tbl[i].tg);
      cycle();
      chk($sformatf("tbl%0d_addr", i),   pm_addr[0],  tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i),  ifid_val[0], tbl[i].e_valid);
      chk($sformatf("tbl%0d_busy", i),   busy_w[0],   tbl[i].e_busy);
      chk($sformatf("tbl%0d_halted", i), halted_w[0], tbl[i].e_halted);
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_ifpc", i), ifid_pcw[0], tbl[i].e_ipc);
      if (tbl[i].ci) chk($sformatf("tbl%0d_instr", i), ifid_ins[0], tbl[i].e_instr);
    end

    // ---- wrap vs. end-of-memory halt, no HALT words ----
    prog[4] = 10'h044;
    do_reset();
    drive(1, 0, 0, 4'd0);
    cycle();
    drive(0, 0, 0, 4'd0);
    for (int k = 1; k <= 19; k++) begin
      cycle();
      if (k >= 15 && k <= 18) begin
        chk($sformatf("wrap_ifpc_k%0d", k), ifid_pcw[0], wrap_exp[k-15]);
        chk($sformatf("wrap_valid_k%0d", k), ifid_val[0], 1);
      end
      if (k == 16) begin
        chk("nw_last_ifpc", ifid_pcw[1], 15);
        chk("nw_last_valid", ifid_val[1], 1);
        chk("nw_last_addr", pm_addr[1], 15);
      end
      if (k == 17) begin
        chk("nw_drain_valid", ifid_val[1], 0);
        chk("nw_drain_busy", busy_w[1], 1);
        chk("nw_drain_halted", halted_w[1], 0);
      end
      if (k >= 18) begin
        chk($sformatf("nw_halted_k%0d", k), halted_w[1], 1);
        chk($sformatf("nw_addr_k%0d", k), pm_addr[1], 15);
        chk($sformatf("nw_busy_k%0d", k), busy_w[1], 0);
      end
    end

    // ---- branch out of DRAIN, stall inside DRAIN ----
    prog[3] = 10'h3C3;
    do_reset();
    drive(1, 0, 0, 4'd0);
    cycle();
    drive(0, 0, 0, 4'd0);
    repeat (4) cycle();
    chk("dr_enter_ifpc", ifid_pcw[0], 3);
    chk("dr_enter_valid", ifid_val[0], 1);
    drive(0, 0, 1, 4'd2);
    cycle();
    chk("dr_br_valid", ifid_val[0], 0);
    chk("dr_br_instr", ifid_ins[0], NOP);
    chk("dr_br_addr", pm_addr[0], 2);
    chk("dr_br_busy", busy_w[0], 1);
    drive(0, 0, 0, 4'd0);
    cycle();
    chk("dr_resume_ifpc", ifid_pcw[0], 2);
    chk("dr_resume_valid", ifid_val[0], 1);
    chk("dr_resume_addr", pm_addr[0], 3);
    cycle();
    chk("dr_again_ifpc", ifid_pcw[0], 3);
    drive(0, 1, 0, 4'd0);
    cycle();
    chk("dr_stall_valid", ifid_val[0], 1);
    chk("dr_stall_ifpc", ifid_pcw[0], 3);
    drive(0, 0, 0, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      cycle();
      chk($sformatf("dr_count_halted_k%0d", k), halted_w[0], int'(k == 3));
      chk($sformatf("dr_count_valid_k%0d", k), ifid_val[0], 0);
    end

    // ---- asynchronous reset mid-RUN, then restart out of HALT ----
    do_reset();
    drive(1, 0, 0, 4'd0);
    cycle();
    drive(0, 0, 0, 4'd0);
    repeat (2) cycle();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_vals(0, "arst");
    check_reset_vals(1, "arst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 4'd0);
    cycle();
    drive(0, 0, 0, 4'd0);
    repeat (7) cycle();
    chk("ar_halted", halted_w[0], 1);
    chk("ar_halt_addr", pm_addr[0], 3);
    drive(1, 0, 0, 4'd0);
    cycle();
    chk("ar_restart_addr", pm_addr[0], 0);
    chk("ar_restart_busy", busy_w[0], 1);
    chk("ar_restart_halted", halted_w[0], 0);
    drive(0, 0, 0, 4'd0);
    cycle();
    chk("ar_first_ifpc", ifid_pcw[0], 0);
    chk("ar_first_valid", ifid_val[0], 1);

    // ---- randomized runs against the model, both builds ----
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 16; k++) begin
        w = 10'($urandom_range(0, 1023));
        if ($urandom_range(0, 5) == 0) w[9:6] = 4'hF;
        else if (w[9:6] == 4'hF) w[9:6] = 4'h0;
        prog[k] = w;
      end
      do_reset();
      model_reset();
      for (int c = 0; c < 300; c++) begin
        logic st, sl, br;
        logic [3:0] tg;
        st = ($urandom_range(0, 7) == 0);
        sl = ($urandom_range(0, 4) == 0);
        br = ($urandom_range(0, 7) == 0);
        tg = 4'($urandom_range(0, 15));
        drive(st, sl, br, tg);
        model_step(0, st, sl, br, int'(tg));
        model_step(1, st, sl, br, int'(tg));
        cycle();
        model_check(0, c);
        model_check(1, c);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
